// File: rtl/ls_port_arbiter_if.sv
// Bus bundle between the local-store arbiter, its two requesters and the local-store macro.
// Signal names follow the arbiter's port list; the master side is the requester/memory environment.
interface ls_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 128
);
  // Handshakes: dp_req/if_req are held with stable payload until accepted. A dp request is
  // accepted in any cycle where dp_req=1 and dp_stall=0; a fetch when if_gnt=1. rvalid lines are
  // single-cycle pulses with no back-pressure, one cycle after an accepted read.
  logic              dp_req;
  logic              dp_wr_en;
  logic [ADDR_W-1:0] dp_addr;
  logic [DATA_W-1:0] dp_wdata;
  logic              dp_stall;
  logic [DATA_W-1:0] dp_rdata;
  logic              dp_rvalid;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;
  logic              mem_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output dp_req, dp_wr_en, dp_addr, dp_wdata, if_req, if_addr, mem_rdata,
    input  dp_stall, dp_rdata, dp_rvalid, if_gnt, if_rdata, if_rvalid,
    input  mem_en, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    input  dp_req, dp_wr_en, dp_addr, dp_wdata, if_req, if_addr, mem_rdata,
    output dp_stall, dp_rdata, dp_rvalid, if_gnt, if_rdata, if_rvalid,
    output mem_en, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ls_port_arbiter.sv
// Local-store arbiter: odd-pipe data port wins by default, fetch is forced after STARVE_MAX
// consecutive denials. Read data returns one cycle after grant, steered by a registered tag.
module ls_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  ls_port_arbiter_if.slave     bus,
  output logic                 o_dbg_state,
  output logic [3:0]           o_dbg_starve_cnt
);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_FORCE = 1'b1
  } state_e;

  localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_starve_cnt;
  logic [3:0]        w_starve_nxt;
  logic              w_dp_gnt;
  logic              w_if_gnt;
  logic              r_tag_valid;
  logic              r_tag_if;
  logic [DATA_W-1:0] r_dp_rdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_dp_rvalid;
  logic              w_if_rvalid;

  // Grants are masked while reset is low so nothing reaches the store during reset.
  always_comb begin
    w_dp_gnt    = 1'b0;
    w_if_gnt    = 1'b0;
    w_state_nxt = ST_ARB;
    if (reset) begin
      if (r_state == ST_FORCE && bus.if_req) begin
        w_if_gnt = 1'b1;
      end else if (bus.dp_req) begin
        w_dp_gnt = 1'b1;
      end else if (bus.if_req) begin
        w_if_gnt = 1'b1;
      end
      if (r_state == ST_ARB && bus.if_req && !w_if_gnt && r_starve_cnt >= LP_MAX - 4'd1) begin
        w_state_nxt = ST_FORCE;
      end
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!bus.if_req || w_if_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve_cnt < LP_MAX) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ARB;
      r_starve_cnt <= 4'd0;
      r_tag_valid  <= 1'b0;
      r_tag_if     <= 1'b0;
      r_dp_rdata   <= '0;
      r_if_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_tag_valid  <= (w_dp_gnt & ~bus.dp_wr_en) | w_if_gnt;
      r_tag_if     <= w_if_gnt;
      if (w_dp_rvalid) r_dp_rdata <= bus.mem_rdata;
      if (w_if_rvalid) r_if_rdata <= bus.mem_rdata;
    end
  end

  assign w_sel_addr    = w_dp_gnt ? bus.dp_addr : (w_if_gnt ? bus.if_addr : '0);
  assign bus.mem_en    = w_dp_gnt | w_if_gnt;
  assign bus.mem_wr_en = w_dp_gnt & bus.dp_wr_en;
  // Low nibble dropped: accesses are always whole quadwords.
  assign bus.mem_addr  = w_sel_addr & {{(ADDR_W-4){1'b1}}, 4'b0000};
  assign bus.mem_wdata = w_dp_gnt ? bus.dp_wdata : '0;

  assign bus.dp_stall  = bus.dp_req & ~w_dp_gnt & reset;
  assign bus.if_gnt    = w_if_gnt;

  assign w_dp_rvalid   = r_tag_valid & ~r_tag_if;
  assign w_if_rvalid   = r_tag_valid & r_tag_if;
  assign bus.dp_rvalid = w_dp_rvalid;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.dp_rdata  = w_dp_rvalid ? bus.mem_rdata : r_dp_rdata;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : r_if_rdata;

  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Directed bench for ls_port_arbiter: driver issues cycle vectors with hand-derived grants,
// a negedge monitor matches every rvalid pulse against expected-data queues.
module tb_ls_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 128;

  logic       clock;
  logic       reset;
  logic       dbg_state;
  logic [3:0] dbg_cnt;
  int         n_pass;
  int         n_total;
  int         cyc_cnt;

  logic [DW-1:0] mem_model [0:2047];
  logic [DW-1:0] ref_mem   [0:2047];

  logic [DW-1:0] dp_exp_q[$];
  int            dp_cyc_q[$];
  logic [DW-1:0] if_exp_q[$];
  int            if_cyc_q[$];

  ls_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ls_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .o_dbg_state      (dbg_state),
    .o_dbg_starve_cnt (dbg_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [DW-1:0] pat(input int idx);
    logic [31:0] w;
    w = 32'h5A00_0000 | 32'(idx);
    return {w, w, w, w};
  endfunction

  // Local-store model: synchronous, one-cycle read latency.
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_wr_en) mem_model[bus.mem_addr[AW-1:4]] <= bus.mem_wdata;
      else               bus.mem_rdata <= mem_model[bus.mem_addr[AW-1:4]];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
  endtask

  // Monitor: rvalid must pulse exactly in the cycle recorded at grant time.
  initial begin
    logic exp_rv;
    forever begin
      @(negedge clock);
      exp_rv = (dp_cyc_q.size() > 0) && (dp_cyc_q[0] == cyc_cnt);
      chk("dp_rvalid", DW'(bus.dp_rvalid), DW'(exp_rv));
      if (exp_rv) begin
        chk("dp_rdata", bus.dp_rdata, dp_exp_q[0]);
        void'(dp_exp_q.pop_front());
        void'(dp_cyc_q.pop_front());
      end
      exp_rv = (if_cyc_q.size() > 0) && (if_cyc_q[0] == cyc_cnt);
      chk("if_rvalid", DW'(bus.if_rvalid), DW'(exp_rv));
      if (exp_rv) begin
        chk("if_rdata", bus.if_rdata, if_exp_q[0]);
        void'(if_exp_q.pop_front());
        void'(if_cyc_q.pop_front());
      end
    end
  end

  // One arbitration cycle. Called just after a posedge; returns just after the next one.
  task automatic step(input logic dq, input logic dw, input logic [AW-1:0] da,
                      input logic [DW-1:0] dd, input logic iq, input logic [AW-1:0] ia,
                      input logic e_dg, input logic e_ig, input int e_st, input int e_cnt,
                      input string nm);
    logic [AW-1:0] a_al;
    bus.dp_req   = dq;
    bus.dp_wr_en = dw;
    bus.dp_addr  = da;
    bus.dp_wdata = dd;
    bus.if_req   = iq;
    bus.if_addr  = ia;
    @(negedge clock);
    chk({nm, ".dp_stall"}, DW'(bus.dp_stall), DW'(dq & ~e_dg));
    chk({nm, ".if_gnt"},   DW'(bus.if_gnt),   DW'(e_ig));
    chk({nm, ".mem_en"},   DW'(bus.mem_en),   DW'(e_dg | e_ig));
    if (e_st >= 0) chk({nm, ".state"}, DW'(dbg_state), DW'(e_st));
    if (e_cnt >= 0) chk({nm, ".starve_cnt"}, DW'(dbg_cnt), DW'(e_cnt));
    if (e_dg) begin
      a_al = {da[AW-1:4], 4'h0};
      chk({nm, ".mem_addr"},  DW'(bus.mem_addr),  DW'(a_al));
      chk({nm, ".mem_wr_en"}, DW'(bus.mem_wr_en), DW'(dw));
      if (dw) begin
        chk({nm, ".mem_wdata"}, bus.mem_wdata, dd);
        ref_mem[da[AW-1:4]] = dd;
      end else begin
        dp_exp_q.push_back(ref_mem[da[AW-1:4]]);
        dp_cyc_q.push_back(cyc_cnt + 1);
      end
    end else if (e_ig) begin
      a_al = {ia[AW-1:4], 4'h0};
      chk({nm, ".mem_addr"},  DW'(bus.mem_addr),  DW'(a_al));
      chk({nm, ".mem_wr_en"}, DW'(bus.mem_wr_en), DW'(0));
      if_exp_q.push_back(ref_mem[ia[AW-1:4]]);
      if_cyc_q.push_back(cyc_cnt + 1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, -1, -1, "idle");
  endtask

  localparam logic [DW-1:0] WDATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 2048; i++) begin
      mem_model[i] = pat(i);
      ref_mem[i]   = pat(i);
    end
    bus.mem_rdata = '0;
    bus.dp_req = 1'b0; bus.dp_wr_en = 1'b0; bus.dp_addr = '0; bus.dp_wdata = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    reset = 1'b0;

    // Reset held: inputs wiggle, outputs stay quiet.
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      bus.dp_req   = 1'($urandom_range(0, 1));
      bus.dp_wr_en = 1'($urandom_range(0, 1));
      bus.dp_addr  = AW'($urandom_range(0, 32767));
      bus.dp_wdata = {4{$urandom}};
      bus.if_req   = 1'($urandom_range(0, 1));
      bus.if_addr  = AW'($urandom_range(0, 32767));
      @(negedge clock);
      chk("rst.dp_stall", DW'(bus.dp_stall), '0);
      chk("rst.if_gnt",   DW'(bus.if_gnt),   '0);
      chk("rst.dp_rdata", bus.dp_rdata,      '0);
      chk("rst.if_rdata", bus.if_rdata,      '0);
      chk("rst.state",    DW'(dbg_state),    '0);
    end
    bus.dp_req = 1'b0; bus.if_req = 1'b0; bus.dp_wr_en = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;

    // First read after reset.
    step(1'b1, 1'b0, 15'h0010, '0, 1'b0, '0, 1'b1, 1'b0, 0, 0, "t1_rd");
    idle(1);

    // Priority with starve_cnt=0.
    step(1'b1, 1'b0, 15'h0020, '0, 1'b1, 15'h0200, 1'b1, 1'b0, 0, 0, "t2_prio");
    step(1'b0, 1'b0, '0, '0, 1'b1, 15'h0200, 1'b0, 1'b1, 0, 1, "t2_fetch");
    idle(1);

    // Starvation: fetch forced in cycle 5, dp stalled there, count restarts.
    step(1'b1, 1'b0, 15'h0400, '0, 1'b1, 15'h0500, 1'b1, 1'b0, 0, 0, "t3_c1");
    step(1'b1, 1'b0, 15'h0410, '0, 1'b1, 15'h0500, 1'b1, 1'b0, 0, 1, "t3_c2");
    step(1'b1, 1'b0, 15'h0420, '0, 1'b1, 15'h0500, 1'b1, 1'b0, 0, 2, "t3_c3");
    step(1'b1, 1'b0, 15'h0430, '0, 1'b1, 15'h0500, 1'b1, 1'b0, 0, 3, "t3_c4");
    step(1'b1, 1'b0, 15'h0440, '0, 1'b1, 15'h0500, 1'b0, 1'b1, 1, 4, "t3_c5");
    step(1'b1, 1'b0, 15'h0440, '0, 1'b1, 15'h0510, 1'b1, 1'b0, 0, 0, "t3_c6");
    step(1'b0, 1'b0, '0, '0, 1'b1, 15'h0510, 1'b0, 1'b1, 0, 1, "t3_c7");
    idle(1);

    // Unaligned store, then load and fetch of the same quadword.
    step(1'b1, 1'b1, 15'h1237, WDATA, 1'b0, '0, 1'b1, 1'b0, 0, 0, "t4_wr");
    step(1'b1, 1'b0, 15'h1230, '0, 1'b0, '0, 1'b1, 1'b0, 0, 0, "t4_rd");
    step(1'b0, 1'b0, '0, '0, 1'b1, 15'h1235, 1'b0, 1'b1, 0, 0, "t4_fetch");
    idle(1);

    // Alternating dp/fetch reads back to back.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 15'h0100, '0, 1'b0, '0, 1'b1, 1'b0, 0, 0, "t5_dp");
      step(1'b0, 1'b0, '0, '0, 1'b1, 15'h0200, 1'b0, 1'b1, 0, 0, "t5_if");
    end
    idle(1);

    // Reset right after a fetch grant drops its return.
    step(1'b0, 1'b0, '0, '0, 1'b1, 15'h0300, 1'b0, 1'b1, 0, 0, "t6_fetch");
    reset = 1'b0;
    bus.if_req = 1'b0;
    if_exp_q.delete();
    if_cyc_q.delete();
    @(negedge clock);
    chk("t6.if_rvalid", DW'(bus.if_rvalid), '0);
    @(posedge clock); #1;
    reset = 1'b1;
    idle(3);
    chk("t6.state", DW'(dbg_state), '0);
    step(1'b1, 1'b0, 15'h0330, '0, 1'b0, '0, 1'b1, 1'b0, 0, 0, "t6_after");
    idle(2);

    chk("dp_q_drained", DW'(dp_exp_q.size()), '0);
    chk("if_q_drained", DW'(if_exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
